e203_exu_csr_rmw_seq: RTL
=========================

// Module: e203_exu_csr_rmw_seq
// PURPOSE
//  Sequences one Zicsr instruction (CSRRW/RS/RC and immediate forms) into the e203_exu_csr access port.
//  Sits between ALU issue and the CSR file. Accepts one op per valid/ready handshake.
//  Performs the read, then the conditional modify-write, then returns the old CSR value for rd writeback.
//  Single-outstanding: it takes no new op until writeback completes.
// PARAMETERS
//  XLEN    32  datapath width; must equal E203_XLEN
//  RDIDX_W 5   destination register index width
// PORTS
//  clk            in   1       core clock
//  rst            in   1       asynchronous reset, active-high
//  i_valid        in   1       issue valid
//  i_ready        out  1       issue ready; high only in IDLE
//  i_op           in   2       01=RW 10=RS 11=RC 00=illegal
//  i_imm          in   1       1: source = zero-extended i_zimm; 0: source = i_rs1_dat
//  i_zimm         in   5       immediate / rs1 field
//  i_rs1_dat      in   XLEN    rs1 operand
//  i_rd_idx       in   RDIDX_W destination index; 0 means x0
//  i_csr_idx      in   12      CSR address
//  i_flush        in   1       pipeline flush
//  csr_ena        out  1       CSR access strobe (RD or WR state)
//  csr_rd_en      out  1       CSR read enable
//  csr_wr_en      out  1       CSR write enable
//  csr_idx        out  12      registered CSR address
//  wbck_csr_dat   out  XLEN    CSR write data
//  read_csr_dat   in   XLEN    CSR read data; combinational from csr_idx
//  csr_access_ilgl in  1       illegal-access flag from the CSR file
//  o_wbck_valid   out  1       rd writeback valid
//  o_wbck_ready   in   1       rd writeback ready
//  o_wbck_dat     out  XLEN    old CSR value; 0 when o_wbck_ilgl
//  o_wbck_rd_idx  out  RDIDX_W destination index
//  o_wbck_ilgl    out  1       illegal-instruction indication to commit
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; every output = 0 except i_ready = 1.
//    All capture registers = 0. Upstream issues no op while rst=1.
//  FSM states: IDLE -> RD -> [WR] -> WB -> IDLE.
//  IDLE
//    i_valid & i_ready: capture op, source, rd_idx, csr_idx.
//    Compute flags:
//      rd_sup = (op==RW) & (rd_idx==0)          suppresses the read
//      wr_sup = (op!=RW) & (i_zimm==0)          suppresses the write
//    op==00 goes straight to WB with ilgl=1.
//  RD (1 cycle)
//    csr_ena=1, csr_rd_en=~rd_sup.
//    Sample old = read_csr_dat (0 if rd_sup); sample ilgl = csr_access_ilgl.
//    Next state:
//      i_flush    -> IDLE, no write
//      ilgl=1     -> WB
//      wr_sup=1   -> WB
//      otherwise  -> WR
//  WR (1 cycle)
//    csr_ena=1, csr_wr_en=1. Write data (src = zimm zero-extended or rs1):
//      RW: src
//      RS: old | src
//      RC: old & ~src
//    i_flush is ignored from WR onward; the write has committed.
//    Next state: WB.
//  WB
//    o_wbck_valid=1 and held stable until o_wbck_ready; transfer -> IDLE.
//  Outputs by state
//    csr_rd_en and csr_wr_en are never high in the same cycle.
//    csr_ena=0 in IDLE and WB.
//    wbck_csr_dat = 0 outside WR.
//  Latency
//    Full RMW: accept at T, RD T+1, WR T+2, o_wbck_valid T+3.
//    Write-suppressed or illegal: o_wbck_valid at T+2.
//    op==00: o_wbck_valid at T+1.
//  Back-to-back: with o_wbck_ready=1, the next op is accepted the cycle after the WB transfer.
//  Reset mid-operation: abort immediately to IDLE; no CSR write is issued after rst rises.
// TESTING
//  1. CSRRW rs1=0xDEADBEEF to 0x305, old=0x80, rd=5
//     -> wr_en at T+2 with 0xDEADBEEF; wbck dat=0x80 rd=5 at T+3
//  2. CSRRS rs1=0x0000_0008 to 0x300, old=0x1800
//     -> write 0x1808; CSRRC same operand -> write 0x1800
//  3. CSRRSI zimm=0 -> no csr_wr_en ever; wbck at T+2 with old value
//     CSRRW rd=0 -> csr_rd_en stays 0
//  4. csr_access_ilgl=1 in RD -> no write; o_wbck_ilgl=1, dat=0 at T+2
//     op=00 -> ilgl=1 at T+1
//  5. Hold o_wbck_ready=0 for 4 cycles -> valid/data stable, i_ready=0
//     Flush in RD -> no write, back to IDLE
//  6. Assert rst during WR -> csr_wr_en drops same cycle
//     All outputs return to reset values; i_ready=1

Source files
------------

// File: rtl/e203_exu_csr_rmw_seq.sv
// -----------------------------------------------------------------------------
// e203_exu_csr_rmw_seq
//
// Sequences one Zicsr instruction (CSRRW/CSRRS/CSRRC and their immediate
// forms) into the CSR file access port. It sits between ALU issue and the CSR
// file and holds at most one instruction at a time:
//   IDLE -> RD -> [WR] -> WB -> IDLE
// The old CSR value is read in RD, the modified value is written in WR (unless
// the write is suppressed or the access is illegal), and the old value is
// returned for rd writeback in WB.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   i_valid/i_ready   issue handshake; i_ready is high only in IDLE
//   i_op              01=RW 10=RS 11=RC 00=illegal
//   i_imm, i_zimm     immediate select and 5-bit immediate / rs1 index field
//   i_rs1_dat         rs1 operand
//   i_rd_idx          destination register index (0 = x0)
//   i_csr_idx         CSR address
//   i_flush           pipeline flush, honoured only while in RD
//   csr_ena           CSR access strobe (RD or WR)
//   csr_rd_en         CSR read enable (RD, unless the read is suppressed)
//   csr_wr_en         CSR write enable (WR)
//   csr_idx           registered CSR address
//   wbck_csr_dat      CSR write data, zero outside WR
//   read_csr_dat      CSR read data, combinational from csr_idx
//   csr_access_ilgl   illegal-access flag from the CSR file, sampled in RD
//   o_wbck_*          rd writeback channel (valid/ready, data, index, illegal)
// -----------------------------------------------------------------------------
module e203_exu_csr_rmw_seq #(
  parameter int XLEN    = 32,
  parameter int RDIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  // issue side
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [1:0]         i_op,
  input  logic               i_imm,
  input  logic [4:0]         i_zimm,
  input  logic [XLEN-1:0]    i_rs1_dat,
  input  logic [RDIDX_W-1:0] i_rd_idx,
  input  logic [11:0]        i_csr_idx,
  input  logic               i_flush,
  // CSR file access port
  output logic               csr_ena,
  output logic               csr_rd_en,
  output logic               csr_wr_en,
  output logic [11:0]        csr_idx,
  output logic [XLEN-1:0]    wbck_csr_dat,
  input  logic [XLEN-1:0]    read_csr_dat,
  input  logic               csr_access_ilgl,
  // rd writeback
  output logic               o_wbck_valid,
  input  logic               o_wbck_ready,
  output logic [XLEN-1:0]    o_wbck_dat,
  output logic [RDIDX_W-1:0] o_wbck_rd_idx,
  output logic               o_wbck_ilgl
);

  localparam logic [1:0] OP_ILGL = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t               state_q;
  logic [1:0]           op_q;
  logic [XLEN-1:0]      src_q;
  logic [RDIDX_W-1:0]   rd_idx_q;
  logic                 rd_sup_q;
  logic                 wr_sup_q;
  logic [XLEN-1:0]      old_q;

  logic [XLEN-1:0]      src_sel;
  logic                 rd_sup_in;
  logic                 wr_sup_in;
  logic [XLEN-1:0]      old_rd;
  logic [XLEN-1:0]      wr_dat;

  // Operand source: zero-extended immediate or the rs1 register value.
  assign src_sel = i_imm ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1_dat;

  // CSRRW with rd=x0 must not produce read side effects; CSRRS/CSRRC with
  // rs1=x0 (or zimm=0) must not produce write side effects.
  assign rd_sup_in = (i_op == OP_RW) & (i_rd_idx == '0);
  assign wr_sup_in = (i_op != OP_RW) & (i_zimm == 5'd0);

  // Old value as seen by both the modify step and rd writeback.
  assign old_rd = rd_sup_q ? '0 : read_csr_dat;

  // Modify step, evaluated during RD against the live read data.
  always_comb begin
    wr_dat = '0;
    case (op_q)
      OP_RW:   wr_dat = src_q;
      OP_RS:   wr_dat = old_rd | src_q;
      OP_RC:   wr_dat = old_rd & ~src_q;
      default: wr_dat = '0;
    endcase
  end

  // Single FSM with registered outputs. Because every output is a flop on the
  // asynchronous reset, raising rst mid-operation drops csr_wr_en at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      src_q         <= '0;
      rd_idx_q      <= '0;
      rd_sup_q      <= 1'b0;
      wr_sup_q      <= 1'b0;
      old_q         <= '0;
      i_ready       <= 1'b1;
      csr_ena       <= 1'b0;
      csr_rd_en     <= 1'b0;
      csr_wr_en     <= 1'b0;
      csr_idx       <= '0;
      wbck_csr_dat  <= '0;
      o_wbck_valid  <= 1'b0;
      o_wbck_dat    <= '0;
      o_wbck_rd_idx <= '0;
      o_wbck_ilgl   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid & i_ready) begin
            op_q     <= i_op;
            src_q    <= src_sel;
            rd_idx_q <= i_rd_idx;
            rd_sup_q <= rd_sup_in;
            wr_sup_q <= wr_sup_in;
            csr_idx  <= i_csr_idx;
            i_ready  <= 1'b0;
            if (i_op == OP_ILGL) begin
              // Undefined encoding: no CSR access, report illegal directly.
              state_q       <= ST_WB;
              o_wbck_valid  <= 1'b1;
              o_wbck_dat    <= '0;
              o_wbck_rd_idx <= i_rd_idx;
              o_wbck_ilgl   <= 1'b1;
            end else begin
              state_q   <= ST_RD;
              csr_ena   <= 1'b1;
              csr_rd_en <= ~rd_sup_in;
            end
          end
        end

        ST_RD: begin
          csr_ena   <= 1'b0;
          csr_rd_en <= 1'b0;
          if (i_flush) begin
            // Nothing has been written yet, so the op can simply vanish.
            state_q <= ST_IDLE;
            i_ready <= 1'b1;
          end else if (csr_access_ilgl) begin
            state_q       <= ST_WB;
            o_wbck_valid  <= 1'b1;
            o_wbck_dat    <= '0;
            o_wbck_rd_idx <= rd_idx_q;
            o_wbck_ilgl   <= 1'b1;
          end else if (wr_sup_q) begin
            state_q       <= ST_WB;
            o_wbck_valid  <= 1'b1;
            o_wbck_dat    <= old_rd;
            o_wbck_rd_idx <= rd_idx_q;
            o_wbck_ilgl   <= 1'b0;
          end else begin
            state_q      <= ST_WR;
            csr_ena      <= 1'b1;
            csr_wr_en    <= 1'b1;
            wbck_csr_dat <= wr_dat;
            old_q        <= old_rd;
          end
        end

        ST_WR: begin
          // The write commits this cycle; a flush can no longer cancel it.
          csr_ena       <= 1'b0;
          csr_wr_en     <= 1'b0;
          wbck_csr_dat  <= '0;
          state_q       <= ST_WB;
          o_wbck_valid  <= 1'b1;
          o_wbck_dat    <= old_q;
          o_wbck_rd_idx <= rd_idx_q;
          o_wbck_ilgl   <= 1'b0;
        end

        ST_WB: begin
          // Writeback outputs hold until the consumer accepts them.
          if (o_wbck_ready) begin
            state_q       <= ST_IDLE;
            i_ready       <= 1'b1;
            o_wbck_valid  <= 1'b0;
            o_wbck_dat    <= '0;
            o_wbck_rd_idx <= '0;
            o_wbck_ilgl   <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          i_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
